// File: rtl/gpi_debounce.sv
// Purpose: per-bit two-flop synchroniser plus stability-count debouncer for slow board inputs.
// Latency: DebounceCycles+2 clk_sys_i cycles from a raw level change to gp_o (and edge pulses).
// Backpressure: none; free-running, every bit is sampled every cycle.
//
// Ports:
//   clk_sys_i  - system clock, the only clock domain
//   rst_sys_ni - synchronous active-low reset
//   raw_i      - asynchronous raw pin levels, one bit per input
//   gp_o       - debounced levels
//   rise_o     - one-cycle pulse per bit when gp_o first reads 1
//   fall_o     - one-cycle pulse per bit when gp_o first reads 0
// Build option: define GPI_DEBOUNCE_EDGE_EN to generate rise_o/fall_o logic;
// otherwise both ports are tied to 0 and gp_o behaves identically.

module gpi_debounce #(
  parameter int unsigned Width          = 8,
  parameter int unsigned CntWidth       = 20,
  parameter int unsigned DebounceCycles = 500000
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  localparam logic [63:0] MaxCycles = (64'd1 << CntWidth) - 64'd1;
  // Terminal count: the mismatch that arrives with the counter here is the
  // DebounceCycles-th consecutive one, so the new level is accepted.
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

  if ((DebounceCycles < 1) || (64'(DebounceCycles) > MaxCycles)) begin : g_bad_cycles
    $error("gpi_debounce: DebounceCycles must be in 1 .. 2**CntWidth-1");
  end

  logic [Width-1:0]    s1_q;
  logic [Width-1:0]    s2_q;
  logic [Width-1:0]    stable_q;
  logic [Width-1:0]    stable_d;
  logic [CntWidth-1:0] cnt_q [Width];
  logic [CntWidth-1:0] cnt_d [Width];

  // Per-bit stability filter. Any cycle where the synchronised input agrees
  // with the accepted level throws away the partial count, so a bounce must
  // restart from zero; the counter stops at CntMax and never wraps.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < Width; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gp_o = stable_q;

`ifdef GPI_DEBOUNCE_EDGE_EN
  logic [Width-1:0] rise_q;
  logic [Width-1:0] fall_q;

  // Pulses are registered from the same next-state value that loads
  // stable_q, so each one lines up with the first cycle gp_o shows the new
  // level. A bit can only move one way per cycle, so rise and fall are
  // mutually exclusive by construction.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= stable_d & ~stable_q;
      fall_q <= ~stable_d & stable_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Purpose: self-checking bench for gpi_debounce with DebounceCycles=4.
// Latency: expectations assume raw->gp_o of 6 cycles (edge k+5 for a change before edge k).
// Backpressure: n/a.

module tb_gpi_debounce;

  localparam int unsigned W = 8;

  logic         clk_sys_i;
  logic         rst_sys_ni;
  logic [W-1:0] raw_i;
  logic [W-1:0] gp_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;

  typedef struct packed {
    logic [W-1:0] gp;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  gpi_debounce #(
    .Width         (8),
    .CntWidth      (20),
    .DebounceCycles(4)
  ) u_dut (
    .clk_sys_i (clk_sys_i),
    .rst_sys_ni(rst_sys_ni),
    .raw_i     (raw_i),
    .gp_o      (gp_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o)
  );

  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what the
  // outputs must show right after the following rising edge.
  task automatic step(input logic [W-1:0] raw, input logic rst_n,
                      input logic [W-1:0] e_gp, input logic [W-1:0] e_rise,
                      input logic [W-1:0] e_fall);
    exp_t e;
    @(negedge clk_sys_i);
    raw_i      = raw;
    rst_sys_ni = rst_n;
    e.gp   = e_gp;
`ifdef GPI_DEBOUNCE_EDGE_EN
    e.rise = e_rise;
    e.fall = e_fall;
`else
    e.rise = '0;
    e.fall = '0;
`endif
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer: one expectation per rising edge, sampled 1 ns later.
  always begin
    @(posedge clk_sys_i);
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("gp_o",   32'(gp_o),   32'(e.gp));
      chk("rise_o", 32'(rise_o), 32'(e.rise));
      chk("fall_o", 32'(fall_o), 32'(e.fall));
      chk("excl",   32'(rise_o & fall_o), 32'd0);
    end
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    raw_i      = '0;
    rst_sys_ni = 1'b0;

    // Reset state and idle.
    step(8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    step(8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    step(8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
    step(8'h00, 1'b1, 8'h00, 8'h00, 8'h00);

    // Clean rise on bit 0: accepted after edge 5.
    for (int k = 0; k < 8; k++)
      step(8'h01, 1'b1, (k >= 5) ? 8'h01 : 8'h00, (k == 5) ? 8'h01 : 8'h00, 8'h00);

    // Bounce on bit 1: 3 high / 3 low twice, then a real hold.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 6; k++)
        step((k < 3) ? 8'h03 : 8'h01, 1'b1, 8'h01, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++)
      step(8'h03, 1'b1, (k >= 5) ? 8'h03 : 8'h01, (k == 5) ? 8'h02 : 8'h00, 8'h00);

    // Bring bit 2 high, then fall.
    for (int k = 0; k < 8; k++)
      step(8'h07, 1'b1, (k >= 5) ? 8'h07 : 8'h03, (k == 5) ? 8'h04 : 8'h00, 8'h00);
    for (int k = 0; k < 8; k++)
      step(8'h03, 1'b1, (k >= 5) ? 8'h03 : 8'h07, 8'h00, (k == 5) ? 8'h04 : 8'h00);

    // Bit 3 rises; reset hits at cycle 3 of the count. Everything clears and
    // all held-high bits are re-accepted 6 cycles after the release edge.
    for (int k = 0; k < 3; k++)
      step(8'h0B, 1'b1, 8'h03, 8'h00, 8'h00);
    step(8'h0B, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++)
      step(8'h0B, 1'b1, (k >= 5) ? 8'h0B : 8'h00, (k == 5) ? 8'h0B : 8'h00, 8'h00);

    // Multi-bit: clear, then apply A5 at once, then release at once.
    step(8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    step(8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
    step(8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++)
      step(8'hA5, 1'b1, (k >= 5) ? 8'hA5 : 8'h00, (k == 5) ? 8'hA5 : 8'h00, 8'h00);
    for (int k = 0; k < 8; k++)
      step(8'h00, 1'b1, (k >= 5) ? 8'h00 : 8'hA5, 8'h00, (k == 5) ? 8'hA5 : 8'h00);

    // Let the final expectation be consumed, then confirm nothing is left.
    @(posedge clk_sys_i);
    #2;
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
